// File: rtl/fp16_mult_pipe_if.sv
// Operand/result interface for the pipelined fp16 multiplier.
// The requester (master) drives operands and clk_en; the multiplier (slave) returns results.
interface fp16_mult_pipe_if;
  logic        clk_en;
  logic        in_valid;
  logic [15:0] dataa;
  logic [15:0] datab;
  logic        out_valid;
  logic [15:0] result;
  logic        overflow;
  logic        underflow;
  logic        nan;

  modport master (
    output clk_en, in_valid, dataa, datab,
    input  out_valid, result, overflow, underflow, nan
  );

  modport slave (
    input  clk_en, in_valid, dataa, datab,
    output out_valid, result, overflow, underflow, nan
  );
endinterface

// File: rtl/fp16_mult_pipe.sv
// Pipelined IEEE-754 half-precision multiplier, flush-to-zero, round-to-nearest-even.
// S1 classifies, S2 multiplies, S3 rounds/packs; remaining stages delay {valid, result, flags}.
module fp16_mult_pipe #(
  parameter int unsigned LATENCY = 8
) (
  input logic             clock,
  input logic             reset,
  fp16_mult_pipe_if.slave bus
);

  // Tail stage 0 is the S3 register; the last tail stage drives the outputs.
  localparam int unsigned NumTail = LATENCY - 2;

  // ---------------- S1: unpack and classify ----------------
  logic [4:0] ea, eb;
  logic [9:0] fa, fb;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign ea = bus.dataa[14:10];
  assign fa = bus.dataa[9:0];
  assign eb = bus.datab[14:10];
  assign fb = bus.datab[9:0];

  // Subnormals share the zero class (flush-to-zero on input).
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  logic        s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic [4:0]  s1_ea_q, s1_eb_q;
  logic [10:0] s1_ma_q, s1_mb_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_ea_q    <= '0;
      s1_eb_q    <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
    end else if (bus.clk_en) begin
      s1_valid_q <= bus.in_valid;
      s1_sign_q  <= bus.dataa[15] ^ bus.datab[15];
      s1_nan_q   <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s1_inf_q   <= a_inf | b_inf;
      s1_zero_q  <= a_zero | b_zero;
      s1_ea_q    <= ea;
      s1_eb_q    <= eb;
      s1_ma_q    <= {1'b1, fa};
      s1_mb_q    <= {1'b1, fb};
    end
  end

  // ---------------- S2: mantissa multiply, exponent sum ----------------
  logic        s2_valid_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
  logic [21:0] s2_prod_q;
  logic signed [6:0] s2_exp_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_nan_q   <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_prod_q  <= '0;
      s2_exp_q   <= '0;
    end else if (bus.clk_en) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_nan_q   <= s1_nan_q;
      s2_inf_q   <= s1_inf_q;
      s2_zero_q  <= s1_zero_q;
      s2_prod_q  <= {11'b0, s1_ma_q} * {11'b0, s1_mb_q};
      s2_exp_q   <= $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - 7'sd15;
    end
  end

  // ---------------- S3: normalize, round, pack, flags ----------------
  logic [9:0]        frac;
  logic              guard, sticky, round_up;
  logic [10:0]       frac_sum;
  logic signed [6:0] norm_exp, fin_exp;
  logic [15:0]       s3_result;
  logic              s3_ovf, s3_unf, s3_nan;

  always_comb begin
    if (s2_prod_q[21]) begin
      frac     = s2_prod_q[20:11];
      guard    = s2_prod_q[10];
      sticky   = |s2_prod_q[9:0];
      norm_exp = s2_exp_q + 7'sd1;
    end else begin
      frac     = s2_prod_q[19:10];
      guard    = s2_prod_q[9];
      sticky   = |s2_prod_q[8:0];
      norm_exp = s2_exp_q;
    end
    round_up = guard & (sticky | frac[0]);
    // Carry out of the fraction means the mantissa rounded up to 2.0.
    frac_sum = {1'b0, frac} + {10'b0, round_up};
    fin_exp  = frac_sum[10] ? norm_exp + 7'sd1 : norm_exp;

    s3_result = {s2_sign_q, fin_exp[4:0], frac_sum[9:0]};
    s3_ovf    = 1'b0;
    s3_unf    = 1'b0;
    s3_nan    = 1'b0;
    if (s2_nan_q) begin
      s3_result = 16'h7E00;
      s3_nan    = 1'b1;
    end else if (s2_inf_q) begin
      s3_result = {s2_sign_q, 5'h1F, 10'h000};
    end else if (s2_zero_q) begin
      s3_result = {s2_sign_q, 15'h0000};
    end else if (fin_exp >= 7'sd31) begin
      s3_result = {s2_sign_q, 5'h1F, 10'h000};
      s3_ovf    = 1'b1;
    end else if (fin_exp <= 7'sd0) begin
      s3_result = {s2_sign_q, 15'h0000};
      s3_unf    = 1'b1;
    end
  end

  // ---------------- S3..S_LATENCY: result delay line ----------------
  // Data loads only behind a valid bit so outputs hold their last result when idle.
  logic        tail_valid_q [NumTail];
  logic [18:0] tail_data_q  [NumTail];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NumTail); i++) begin
        tail_valid_q[i] <= 1'b0;
        tail_data_q[i]  <= '0;
      end
    end else if (bus.clk_en) begin
      tail_valid_q[0] <= s2_valid_q;
      if (s2_valid_q) tail_data_q[0] <= {s3_result, s3_ovf, s3_unf, s3_nan};
      for (int i = 1; i < int'(NumTail); i++) begin
        tail_valid_q[i] <= tail_valid_q[i-1];
        if (tail_valid_q[i-1]) tail_data_q[i] <= tail_data_q[i-1];
      end
    end
  end

  assign bus.out_valid = tail_valid_q[NumTail-1];
  assign {bus.result, bus.overflow, bus.underflow, bus.nan} = tail_data_q[NumTail-1];

endmodule

// File: tb/tb_fp16_mult_pipe.sv
// Scoreboard bench for fp16_mult_pipe: expected results are queued at issue and
// compared (value, flags and enabled-cycle latency) when out_valid appears.
module tb_fp16_mult_pipe;

  localparam int unsigned Latency = 8;

  logic clock;
  logic reset;
  fp16_mult_pipe_if bus ();

  fp16_mult_pipe #(.LATENCY(Latency)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [18:0] exp;  // {result, overflow, underflow, nan}
    int          due;
  } sb_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  flg;
  } vec_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  en_edges = 0;
  logic        prev_valid;
  logic [15:0] prev_result;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: exact integer product, rounding by remainder vs. half-ulp comparison.
  function automatic logic [18:0] fp16_model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, fa, fb, p, e, sh, q, r, half;
    logic s;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    ea = int'(a[14:10]); fa = int'(a[9:0]);
    eb = int'(b[14:10]); fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    a_nan = (ea == 31) && (fa != 0); a_inf = (ea == 31) && (fa == 0); a_zero = (ea == 0);
    b_nan = (eb == 31) && (fb != 0); b_inf = (eb == 31) && (fb == 0); b_zero = (eb == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {16'h7E00, 3'b001};
    if (a_inf || b_inf) return {s, 5'h1F, 10'h000, 3'b000};
    if (a_zero || b_zero) return {s, 15'h0000, 3'b000};
    p  = (1024 + fa) * (1024 + fb);
    e  = ea + eb - 15;
    sh = (p >= (1 << 21)) ? 11 : 10;
    if (sh == 11) e++;
    q    = p >> sh;
    r    = p - (q << sh);
    half = 1 << (sh - 1);
    if (r > half || (r == half && (q % 2) == 1)) q++;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e >= 31) return {s, 5'h1F, 10'h000, 3'b100};
    if (e <= 0) return {s, 15'h0000, 3'b010};
    return {s, 5'(e), 10'(q - 1024), 3'b000};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic en,
                       input logic vld, input logic [18:0] exp);
    sb_t item;
    @(negedge clock);
    bus.clk_en   = en;
    bus.in_valid = vld;
    bus.dataa    = a;
    bus.datab    = b;
    if (en && vld) begin
      item.exp = exp;
      item.due = en_edges + int'(Latency);
      sb.push_back(item);
    end
  endtask

  task automatic issue_m(input logic [15:0] a, input logic [15:0] b);
    drive(a, b, 1'b1, 1'b1, fp16_model(a, b));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(16'h0, 16'h0, 1'b1, 1'b0, 19'h0);
  endtask

  task automatic stall(input int n);
    repeat (n) drive(16'h0, 16'h0, 1'b0, 1'b0, 19'h0);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 1) == 1) v[14:10] = 5'($urandom_range(8, 22));
    return v;
  endfunction

  // Output monitor: pops on enabled edges, checks freezing on disabled edges.
  always @(posedge clock) begin
    logic en, rst_seen;
    sb_t  item;
    en       = bus.clk_en;
    rst_seen = reset;
    #1;
    if (rst_seen && reset) begin
      if (en) begin
        en_edges++;
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            check_eq("spurious_out_valid", 32'd1, 32'd0);
          end else begin
            item = sb.pop_front();
            check_eq("latency", 32'(en_edges), 32'(item.due));
            check_eq("result", {16'h0, bus.result}, {16'h0, item.exp[18:3]});
            check_eq("flags", {29'h0, bus.overflow, bus.underflow, bus.nan},
                     {29'h0, item.exp[2:0]});
          end
        end else if (sb.size() != 0 && sb[0].due <= en_edges) begin
          check_eq("missing_out_valid", 32'd0, 32'd1);
          void'(sb.pop_front());
        end
      end else begin
        check_eq("stall_hold_valid", {31'h0, bus.out_valid}, {31'h0, prev_valid});
        check_eq("stall_hold_result", {16'h0, bus.result}, {16'h0, prev_result});
      end
      prev_valid  = bus.out_valid;
      prev_result = bus.result;
    end
  end

  vec_t dir [12] = '{
    '{16'h3C00, 16'h4000, 16'h4000, 3'b000},
    '{16'h7BFF, 16'h4000, 16'h7C00, 3'b100},
    '{16'h0400, 16'h0400, 16'h0000, 3'b010},
    '{16'h8400, 16'h0400, 16'h8000, 3'b010},
    '{16'h7C00, 16'h0000, 16'h7E00, 3'b001},
    '{16'h7E01, 16'h3C00, 16'h7E00, 3'b001},
    '{16'hFC00, 16'h4000, 16'hFC00, 3'b000},
    '{16'h3C01, 16'h3C01, 16'h3C02, 3'b000},
    '{16'h3C01, 16'h4200, 16'h4202, 3'b000},
    '{16'h3BFF, 16'h3C00, 16'h3BFF, 3'b000},
    '{16'h0001, 16'h3C00, 16'h0000, 3'b000},
    '{16'h8000, 16'h3C00, 16'h8000, 3'b000}
  };

  initial begin
    reset        = 1'b0;
    bus.clk_en   = 1'b0;
    bus.in_valid = 1'b0;
    bus.dataa    = '0;
    bus.datab    = '0;
    prev_valid   = 1'b0;
    prev_result  = '0;
    #12;
    check_eq("reset_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check_eq("reset_result", {16'h0, bus.result}, 32'd0);
    check_eq("reset_flags", {29'h0, bus.overflow, bus.underflow, bus.nan}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // First pair alone to expose the exact latency, then the rest back to back.
    drive(dir[0].a, dir[0].b, 1'b1, 1'b1, {dir[0].res, dir[0].flg});
    idle(10);
    for (int i = 1; i < 12; i++) drive(dir[i].a, dir[i].b, 1'b1, 1'b1, {dir[i].res, dir[i].flg});
    idle(10);

    // Four consecutive pairs, stall while results are emerging.
    for (int i = 0; i < 4; i++) issue_m(rand_op(), rand_op());
    idle(6);
    stall(5);
    idle(10);

    // Random traffic with enable and valid gaps.
    for (int i = 0; i < 80; i++) begin
      logic en, vld;
      logic [15:0] a, b;
      en  = ($urandom_range(0, 3) != 0);
      vld = ($urandom_range(0, 2) != 0);
      a   = rand_op();
      b   = rand_op();
      drive(a, b, en, vld, fp16_model(a, b));
    end
    idle(12);

    // Reset with one result showing and three pairs in flight.
    issue_m(16'h3C00, 16'h3C00);
    idle(4);
    for (int i = 0; i < 3; i++) issue_m(rand_op(), rand_op());
    @(posedge clock);
    #2;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("midreset_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check_eq("midreset_flags", {29'h0, bus.overflow, bus.underflow, bus.nan}, 32'd0);
    sb.delete();
    #4;
    reset = 1'b1;
    idle(20);

    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
